ext_pipe: RTL and testbench

- Parametrised, registered extension unit for the pipelined datapath.
- Merges immediate extension (zero, sign, upper-load) with load-data byte/half/word selection and extension in one stage.
- Results pass through a 2-entry elastic buffer with valid/ready on both sides, so the stage can stall without losing data.
- Misaligned loads are flagged per result and counted.

---
 rtl/ext_pipe_if.sv | 29 ++
 rtl/ext_pipe.sv | 158 +++++++++++++++
 tb/tb_ext_pipe.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ext_pipe_if.sv
// Request/result bundle for the extension stage.
// The producer and consumer side use master; the extension unit uses slave.
interface ext_pipe_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int OFF_W  = $clog2(DATA_W/8)
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [DATA_W-1:0] in_data;
  logic [OFF_W-1:0]  in_off;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output in_valid, in_op, in_data, in_off, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_err, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_data, in_off, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_err, out_tag
  );
endinterface

// File: rtl/ext_pipe.sv
// Immediate / load-data extension stage feeding a 2-entry elastic buffer.
// The head entry is held in dedicated registers that drive out_* directly.
module ext_pipe #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int TAG_W  = 5,
  localparam int OFF_W = $clog2(DATA_W/8)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  ext_pipe_if.slave   bus,
  output logic [7:0]  err_cnt
);
  localparam int NB = DATA_W / 8;

  typedef enum logic [2:0] {
    OP_IMM_ZERO = 3'd0,
    OP_IMM_SIGN = 3'd1,
    OP_IMM_HIGH = 3'd2,
    OP_LB_U     = 3'd3,
    OP_LB_S     = 3'd4,
    OP_LH_U     = 3'd5,
    OP_LH_S     = 3'd6,
    OP_LW       = 3'd7
  } op_e;

  logic [7:0]  byte_lane [NB];
  logic [15:0] half_lane [NB/2];

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_byte
      assign byte_lane[gi] = bus.in_data[8*gi +: 8];
    end
    for (gi = 0; gi < NB/2; gi++) begin : g_half
      assign half_lane[gi] = bus.in_data[16*gi +: 16];
    end
  endgenerate

  logic [IMM_W-1:0]  imm;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [DATA_W-1:0] ext_data;
  logic              ext_err;

  always_comb begin
    imm      = bus.in_data[IMM_W-1:0];
    sel_byte = byte_lane[bus.in_off];
    // Halfword lanes are indexed by the offset without its low bit; alignment is checked separately.
    sel_half = half_lane[bus.in_off[OFF_W-1:1]];
    ext_data = '0;
    ext_err  = 1'b0;
    case (op_e'(bus.in_op))
      OP_IMM_ZERO: ext_data = {{(DATA_W-IMM_W){1'b0}}, imm};
      OP_IMM_SIGN: ext_data = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
      OP_IMM_HIGH: ext_data = {imm, {(DATA_W-IMM_W){1'b0}}};
      OP_LB_U:     ext_data = {{(DATA_W-8){1'b0}}, sel_byte};
      OP_LB_S:     ext_data = {{(DATA_W-8){sel_byte[7]}}, sel_byte};
      OP_LH_U:     ext_data = {{(DATA_W-16){1'b0}}, sel_half};
      OP_LH_S:     ext_data = {{(DATA_W-16){sel_half[15]}}, sel_half};
      OP_LW:       ext_data = bus.in_data;
      default:     ext_data = '0;
    endcase
    if ((bus.in_op == OP_LH_U || bus.in_op == OP_LH_S) && bus.in_off[0])
      ext_err = 1'b1;
    if (bus.in_op == OP_LW && bus.in_off != '0)
      ext_err = 1'b1;
    if (ext_err)
      ext_data = '0;
  end

  logic [1:0]        count_q, count_d;
  logic [DATA_W-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic              head_err_q, head_err_d, tail_err_q, tail_err_d;
  logic [TAG_W-1:0]  head_tag_q, head_tag_d, tail_tag_q, tail_tag_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              push, pop;

  // in_ready comes only from the registered count, never from out_ready.
  assign bus.in_ready  = (count_q != 2'd2);
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_data  = head_data_q;
  assign bus.out_err   = head_err_q;
  assign bus.out_tag   = head_tag_q;
  assign err_cnt       = err_cnt_q;

  always_comb begin
    push        = bus.in_valid && bus.in_ready && !flush;
    pop         = bus.out_valid && bus.out_ready && !flush;
    count_d     = count_q;
    head_data_d = head_data_q;
    head_err_d  = head_err_q;
    head_tag_d  = head_tag_q;
    tail_data_d = tail_data_q;
    tail_err_d  = tail_err_q;
    tail_tag_d  = tail_tag_q;
    err_cnt_d   = err_cnt_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_data_d = ext_data;
          head_err_d  = ext_err;
          head_tag_d  = bus.in_tag;
          count_d     = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_data_d = ext_data;
          head_err_d  = ext_err;
          head_tag_d  = bus.in_tag;
        end else if (push) begin
          tail_data_d = ext_data;
          tail_err_d  = ext_err;
          tail_tag_d  = bus.in_tag;
          count_d     = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_data_d = tail_data_q;
          head_err_d  = tail_err_q;
          head_tag_d  = tail_tag_q;
          count_d     = 2'd1;
        end
      end
    endcase
    if (flush)
      count_d = 2'd0;
    if (push && ext_err && err_cnt_q != 8'hFF)
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= 2'd0;
      head_data_q <= '0;
      head_err_q  <= 1'b0;
      head_tag_q  <= '0;
      tail_data_q <= '0;
      tail_err_q  <= 1'b0;
      tail_tag_q  <= '0;
      err_cnt_q   <= 8'd0;
    end else begin
      count_q     <= count_d;
      head_data_q <= head_data_d;
      head_err_q  <= head_err_d;
      head_tag_q  <= head_tag_d;
      tail_data_q <= tail_data_d;
      tail_err_q  <= tail_err_d;
      tail_tag_q  <= tail_tag_d;
      err_cnt_q   <= err_cnt_d;
    end
  end
endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the buffer and extension rules.
module tb_ext_pipe;
  localparam int DATA_W = 32;
  localparam int IMM_W  = 16;
  localparam int TAG_W  = 5;
  localparam int OFF_W  = $clog2(DATA_W/8);

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic [7:0] err_cnt;

  ext_pipe_if #(.DATA_W(DATA_W), .TAG_W(TAG_W), .OFF_W(OFF_W)) bus ();

  ext_pipe #(.DATA_W(DATA_W), .IMM_W(IMM_W), .TAG_W(TAG_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .bus     (bus.slave),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              err;
    logic [TAG_W-1:0]  tag;
  } ent_t;

  ent_t q[$];
  int   m_cnt    = 0;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Extension rules written as plain integer arithmetic on the request.
  function automatic ent_t ref_ext(int op, longint d, int off, logic [TAG_W-1:0] tag);
    ent_t   e;
    longint mask = (longint'(1) << DATA_W) - 1;
    longint imm  = d % (longint'(1) << IMM_W);
    longint b    = (d >> (8 * off)) % 256;
    longint h    = (d >> (8 * off)) % 65536;
    longint r    = 0;
    e.err = 1'b0;
    case (op)
      0: r = imm;
      1: r = (imm >= (longint'(1) << (IMM_W - 1))) ? imm - (longint'(1) << IMM_W) : imm;
      2: r = imm * (longint'(1) << (DATA_W - IMM_W));
      3: r = b;
      4: r = (b >= 128) ? b - 256 : b;
      5: if (off % 2 != 0) e.err = 1'b1; else r = h;
      6: if (off % 2 != 0) e.err = 1'b1; else r = (h >= 32768) ? h - 65536 : h;
      default: if (off != 0) e.err = 1'b1; else r = d;
    endcase
    if (e.err) r = 0;
    e.data = DATA_W'(r & mask);
    e.tag  = tag;
    return e;
  endfunction

  // One clock: check outputs at the falling edge, then advance the model past the rising edge.
  task automatic cycle();
    ent_t e;
    bit   acc, pop;
    @(negedge clk);
    if (!reset) begin
      check("in_ready", bus.in_ready, q.size() != 2);
      check("out_valid", bus.out_valid, q.size() != 0);
      if (q.size() != 0) begin
        check("out_data", bus.out_data, q[0].data);
        check("out_err", bus.out_err, q[0].err);
        check("out_tag", bus.out_tag, q[0].tag);
      end
      check("err_cnt", err_cnt, m_cnt);
    end
    acc = bus.in_valid && (q.size() != 2) && !flush && !reset;
    pop = (q.size() != 0) && bus.out_ready && !flush && !reset;
    e   = ref_ext(int'(bus.in_op), longint'(bus.in_data), int'(bus.in_off), bus.in_tag);
    @(posedge clk);
    #1;
    if (reset) begin
      q.delete();
      m_cnt = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (pop) begin
        $display("pop  tag=%0d data=%h err=%0d", q[0].tag, q[0].data, q[0].err);
        void'(q.pop_front());
      end
      if (acc) begin
        q.push_back(e);
        if (e.err && m_cnt < 255) m_cnt++;
      end
    end
  endtask

  task automatic drive(int op, logic [DATA_W-1:0] d, int off, int tag);
    bus.in_valid = 1'b1;
    bus.in_op    = 3'(op);
    bus.in_data  = d;
    bus.in_off   = OFF_W'(off);
    bus.in_tag   = TAG_W'(tag);
  endtask

  // Single request into an empty buffer; result must be on the outputs one cycle later.
  task automatic single(string tag, int op, logic [DATA_W-1:0] d, int off, logic [DATA_W-1:0] exp);
    bus.out_ready = 1'b1;
    drive(op, d, off, 3);
    cycle();
    bus.in_valid = 1'b0;
    check({tag, "_valid"}, bus.out_valid, 1'b1);
    check({tag, "_data"}, bus.out_data, exp);
    check({tag, "_err"}, bus.out_err, 1'b0);
    cycle();
  endtask

  int saved_cnt;

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1, 32'h0000_8001, 0, 1);
    cycle();
    cycle();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_data", bus.out_data, '0);
    check("rst_out_err", bus.out_err, 1'b0);
    check("rst_out_tag", bus.out_tag, '0);
    check("rst_err_cnt", err_cnt, 8'd0);
    cycle();

    single("imm_sign", 1, 32'h0000_8001, 0, 32'hFFFF_8001);
    single("imm_zero", 0, 32'h0000_8001, 0, 32'h0000_8001);
    single("imm_high", 2, 32'h0000_1234, 0, 32'h1234_0000);
    single("lbs_off1", 4, 32'h80FF_7F01, 1, 32'h0000_007F);
    single("lbs_off2", 4, 32'h80FF_7F01, 2, 32'hFFFF_FFFF);
    single("lbu_off3", 3, 32'h80FF_7F01, 3, 32'h0000_0080);
    single("lhs_off2", 6, 32'h80FF_7F01, 2, 32'hFFFF_80FF);
    single("lhu_off0", 5, 32'h80FF_7F01, 0, 32'h0000_7F01);
    single("lw_off0",  7, 32'h80FF_7F01, 0, 32'h80FF_7F01);

    // Two misaligned loads held in the buffer.
    bus.out_ready = 1'b0;
    drive(6, 32'h80FF_7F01, 1, 7);
    cycle();
    drive(7, 32'h80FF_7F01, 2, 9);
    cycle();
    bus.in_valid = 1'b0;
    check("mis_head_err", bus.out_err, 1'b1);
    check("mis_head_data", bus.out_data, '0);
    check("mis_head_tag", bus.out_tag, 5'd7);
    check("mis_err_cnt", err_cnt, 8'd2);
    bus.out_ready = 1'b1;
    cycle();
    check("mis_tail_tag", bus.out_tag, 5'd9);
    check("mis_tail_err", bus.out_err, 1'b1);
    cycle();

    // Saturation of the misalignment counter.
    drive(7, 32'h1234_5678, 1, 4);
    for (int i = 0; i < 300; i++) cycle();
    bus.in_valid = 1'b0;
    cycle();
    check("sat_err_cnt", err_cnt, 8'd255);
    cycle();

    // Backpressure: three requests while stalled.
    bus.out_ready = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      drive(0, 32'(t * 16'h1111), 0, t);
      cycle();
    end
    check("bp_in_ready", bus.in_ready, 1'b0);
    check("bp_head_tag", bus.out_tag, 5'd1);
    cycle();
    check("bp_stall_data", bus.out_data, 32'h0000_1111);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    // Continuous push/pop at count 1.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(int'($urandom_range(0, 4)), $urandom, int'($urandom_range(0, 3)), i);
      cycle();
      if (i > 0) check("thru_in_ready", bus.in_ready, 1'b1);
    end
    bus.in_valid = 1'b0;
    cycle();

    // Flush with a full buffer and a request pending.
    bus.out_ready = 1'b0;
    drive(7, 32'h0, 1, 1);
    cycle();
    drive(0, 32'h5555, 0, 2);
    cycle();
    saved_cnt = m_cnt;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_out_valid", bus.out_valid, 1'b0);
    check("flush_in_ready", bus.in_ready, 1'b1);
    check("flush_err_cnt", err_cnt, saved_cnt);
    cycle();

    // Reset in the same scenario.
    drive(7, 32'h0, 2, 5);
    cycle();
    drive(1, 32'hABCD, 0, 6);
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    check("reset_err_cnt", err_cnt, 8'd0);
    check("reset_out_data", bus.out_data, '0);
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_in_ready", bus.in_ready, 1'b1);
    cycle();

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_op     = 3'($urandom_range(0, 7));
      bus.in_data   = $urandom;
      bus.in_off    = OFF_W'($urandom_range(0, 3));
      bus.in_tag    = TAG_W'($urandom_range(0, 31));
      bus.out_ready = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 49) == 0);
      cycle();
    end
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
